arm_mc_controller: RTL and testbench

Multicycle control unit for the ARMv4-subset core: one FSM sequences a shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback cycles. Supports ADD, SUB, AND, ORR, CMP, TST, LSL, LDR, STR and B. Owns the NZCV flag register and conditional-execution gating. Sits between the datapath's instruction register and all datapath mux selects and write enables.

---
 rtl/arm_mc_pkg.sv | 69 ++++++
 rtl/mc_condcheck.sv | 36 +++
 rtl/arm_mc_controller.sv | 164 ++++++++++++++++
 tb/tb_arm_mc_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Covers FSM states, datapath select codes and data-processing opcode decode.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
  } statetype_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_LSL = 4'b1101;

  typedef struct packed {
    logic       legal;
    logic [1:0] alu_control;
    logic       no_write;
    logic       shift;
    logic       cv_update;
  } dp_decode_t;

  // LSL exists only in register form; the immediate encoding of 1101 is rejected.
  function automatic dp_decode_t dp_decode(input logic [3:0] cmd, input logic imm);
    dp_decode_t d;
    d = '0;
    d.legal = 1'b1;
    case (cmd)
      CMD_ADD: begin d.alu_control = ALU_ADD; d.cv_update = 1'b1; end
      CMD_SUB: begin d.alu_control = ALU_SUB; d.cv_update = 1'b1; end
      CMD_AND: d.alu_control = ALU_AND;
      CMD_ORR: d.alu_control = ALU_ORR;
      CMD_CMP: begin d.alu_control = ALU_SUB; d.no_write = 1'b1; d.cv_update = 1'b1; end
      CMD_TST: begin d.alu_control = ALU_AND; d.no_write = 1'b1; end
      CMD_LSL: begin d.legal = ~imm; d.shift = ~imm; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_condcheck.sv
// Evaluates an ARM condition field against the stored NZCV flags.
// Condition 1111 is treated as never-execute.
module mc_condcheck (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic neg, zero, carry, ovf, ge;

  assign {neg, zero, carry, ovf} = flags;
  assign ge = (neg == ovf);

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = zero;
      4'b0001: cond_ex = ~zero;
      4'b0010: cond_ex = carry;
      4'b0011: cond_ex = ~carry;
      4'b0100: cond_ex = neg;
      4'b0101: cond_ex = ~neg;
      4'b0110: cond_ex = ovf;
      4'b0111: cond_ex = ~ovf;
      4'b1000: cond_ex = carry & ~zero;
      4'b1001: cond_ex = ~carry | zero;
      4'b1010: cond_ex = ge;
      4'b1011: cond_ex = ~ge;
      4'b1100: cond_ex = ~zero & ge;
      4'b1101: cond_ex = zero | ~ge;
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// holds the NZCV flags and the per-instruction condition-pass bit.
module arm_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       Shift,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Illegal
);

  import arm_mc_pkg::*;

  statetype_t state, next_state;
  logic [3:0] flags;
  logic       cond_ex_reg;
  logic       cond_ex;
  logic       exec_state;
  logic       rd_is_pc;
  logic       flag_write;
  dp_decode_t dp;

  mc_condcheck u_condcheck (
    .cond    (Cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  assign dp         = dp_decode(Funct[4:1], Funct[5]);
  assign exec_state = (state == EXECR) || (state == EXECI);
  assign rd_is_pc   = (Rd == 4'd15);
  assign flag_write = exec_state && dp.legal && !dp.shift && Funct[0] && cond_ex_reg;

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   next_state = MEMADR;
          2'b00:   next_state = Funct[5] ? EXECI : EXECR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      end
      MEMADR: next_state = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  next_state = MEMWB;
      EXECR,
      EXECI:  next_state = (!dp.legal || dp.no_write) ? FETCH : ALUWB;
      default: next_state = FETCH;
    endcase
  end

  // The condition bit is frozen in DECODE, so a flag update during EXEC
  // cannot change whether the same instruction writes back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      flags       <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DECODE)
        cond_ex_reg <= cond_ex;
      if (flag_write) begin
        flags[3:2] <= ALUFlags[3:2];
        if (dp.cv_update)
          flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUControl = ALU_ADD;
    ResultSrc  = RES_ALUOUT;
    ImmSrc     = IMM_8;
    RegSrc     = 2'b00;
    Shift      = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    Illegal    = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        Illegal   = (Op == 2'b11);
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_12;
      end
      MEMRD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = cond_ex_reg;
        PCWrite   = cond_ex_reg & rd_is_pc;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        RegSrc   = 2'b10;
        MemWrite = cond_ex_reg;
      end
      EXECR,
      EXECI: begin
        ALUSrcB = (state == EXECI) ? SRCB_IMM : SRCB_REG;
        if (dp.legal) begin
          ALUControl = dp.alu_control;
          Shift      = dp.shift;
        end else begin
          Illegal = 1'b1;
        end
      end
      ALUWB: begin
        Shift    = dp.shift;
        RegWrite = cond_ex_reg;
        PCWrite  = cond_ex_reg & rd_is_pc;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_24;
        ResultSrc = RES_ALURESULT;
        RegSrc    = 2'b01;
        PCWrite   = cond_ex_reg;
      end
      default: ;
    endcase
    // Whatever state is being abandoned, nothing may be written while reset is held.
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench for arm_mc_controller: per-cycle expected control words
// are queued by the stimulus and compared by an independent monitor.
module tb_arm_mc_controller;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic       shift;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal;
  } out_t;

  localparam int S_FETCH  = 0;
  localparam int S_DECODE = 1;
  localparam int S_MEMADR = 2;
  localparam int S_MEMRD  = 3;
  localparam int S_MEMWB  = 4;
  localparam int S_MEMWR  = 5;
  localparam int S_EXECR  = 6;
  localparam int S_EXECI  = 7;
  localparam int S_ALUWB  = 8;
  localparam int S_BRANCH = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'b0;
  logic [3:0] Cond = 4'b0;
  logic [3:0] ALUFlags = 4'b0;
  logic       IRWrite, AdrSrc, ALUSrcA, Shift, PCWrite, RegWrite, MemWrite, Illegal;
  logic [1:0] ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc;

  out_t  actual;
  out_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  arm_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .Shift      (Shift),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .Illegal    (Illegal)
  );

  always #5 clk = ~clk;

  assign actual = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc,
                   ImmSrc, RegSrc, Shift, PCWrite, RegWrite, MemWrite, Illegal};

  // Nominal control word of each state, before condition-gated enables.
  function automatic out_t base(input int s);
    out_t v;
    v = '0;
    case (s)
      S_FETCH:  begin v.ir_write = 1; v.alu_src_a = 1; v.alu_src_b = 2'b10;
                      v.result_src = 2'b10; v.pc_write = 1; end
      S_DECODE: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; v.result_src = 2'b10; end
      S_MEMADR: begin v.alu_src_b = 2'b01; v.imm_src = 2'b01; end
      S_MEMRD:  v.adr_src = 1;
      S_MEMWB:  v.result_src = 2'b01;
      S_MEMWR:  begin v.adr_src = 1; v.reg_src = 2'b10; end
      S_EXECR:  v.alu_src_b = 2'b00;
      S_EXECI:  begin v.alu_src_b = 2'b01; v.imm_src = 2'b00; end
      S_ALUWB:  v.result_src = 2'b00;
      S_BRANCH: begin v.alu_src_b = 2'b01; v.imm_src = 2'b10; v.result_src = 2'b10;
                      v.reg_src = 2'b01; end
      default:  v = '0;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input out_t e, input string nm);
    n_checks++;
    if (actual !== e) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b required %b", nm, actual, e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checkOutput(e, nm);
    end
  end

  task automatic applyStimulus(input out_t e, input logic [3:0] alu_flags, input string nm);
    ALUFlags = alu_flags;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [31:0] instr);
    Cond  = instr[31:28];
    Op    = instr[27:26];
    Funct = instr[25:20];
    Rd    = instr[15:12];
  endtask

  task automatic fetch_decode(input logic [31:0] instr, input string nm);
    set_ir(instr);
    applyStimulus(base(S_FETCH), 4'b1111, {nm, " fetch"});
    applyStimulus(base(S_DECODE), 4'b1111, {nm, " decode"});
  endtask

  task automatic do_dp(input logic [31:0] instr, input logic [1:0] alu, input logic shift,
                       input logic no_write, input logic illegal, input logic cex,
                       input logic [3:0] exec_flags, input string nm);
    out_t v;
    fetch_decode(instr, nm);
    v = base(instr[25] ? S_EXECI : S_EXECR);
    v.alu_control = alu;
    v.shift = shift;
    v.illegal = illegal;
    applyStimulus(v, exec_flags, {nm, " exec"});
    if (!no_write && !illegal) begin
      v = base(S_ALUWB);
      v.shift = shift;
      v.reg_write = cex;
      v.pc_write = cex && (instr[15:12] == 4'hF);
      applyStimulus(v, 4'b1111, {nm, " aluwb"});
    end
  endtask

  task automatic do_mem(input logic [31:0] instr, input logic cex, input string nm);
    out_t v;
    fetch_decode(instr, nm);
    applyStimulus(base(S_MEMADR), 4'b1111, {nm, " memadr"});
    if (instr[20]) begin
      applyStimulus(base(S_MEMRD), 4'b1111, {nm, " memrd"});
      v = base(S_MEMWB);
      v.reg_write = cex;
      v.pc_write = cex && (instr[15:12] == 4'hF);
      applyStimulus(v, 4'b1111, {nm, " memwb"});
    end else begin
      v = base(S_MEMWR);
      v.mem_write = cex;
      applyStimulus(v, 4'b1111, {nm, " memwr"});
    end
  endtask

  task automatic do_branch(input logic [31:0] instr, input logic taken, input string nm);
    out_t v;
    fetch_decode(instr, nm);
    v = base(S_BRANCH);
    v.pc_write = taken;
    applyStimulus(v, 4'b1111, {nm, " branch"});
  endtask

  task automatic do_illegal_op(input logic [31:0] instr, input string nm);
    out_t v;
    set_ir(instr);
    applyStimulus(base(S_FETCH), 4'b1111, {nm, " fetch"});
    v = base(S_DECODE);
    v.illegal = 1;
    applyStimulus(v, 4'b1111, {nm, " decode"});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    out_t v;
    reset = 1'b1;
    @(posedge clk);
    #1;
    v = base(S_FETCH);
    v.ir_write = 0;
    v.pc_write = 0;
    applyStimulus(v, 4'b1111, "reset cycle gated fetch");
    reset = 1'b0;

    // Flags start at 0000 after reset.
    do_dp(32'hE2801005, 2'b00, 0, 0, 0, 1, 4'b1010, "ADD R1,R0,#5");
    do_mem(32'hE5902004, 1, "LDR R2");
    do_mem(32'hE5802008, 1, "STR R2");
    do_dp(32'hE0513001, 2'b01, 0, 0, 0, 1, 4'b0100, "SUBS R3");      // flags -> 0100
    do_branch(32'h0AFFFFFE, 1, "BEQ after SUBS");
    do_branch(32'h1AFFFFFE, 0, "BNE after SUBS");
    do_dp(32'hE3510005, 2'b01, 0, 1, 0, 1, 4'b0110, "CMP R1,#5");    // flags -> 0110
    do_branch(32'h2AFFFFFE, 1, "BCS after CMP");
    do_dp(32'h02911001, 2'b00, 0, 0, 0, 1, 4'b0000, "ADDEQS R1");    // flags -> 0000
    do_branch(32'h0AFFFFFE, 0, "BEQ after ADDEQS");
    do_branch(32'h3AFFFFFE, 1, "BCC after ADDEQS");
    do_dp(32'hE1A04101, 2'b00, 1, 0, 0, 1, 4'b1111, "LSL R4");
    do_illegal_op(32'hEC000000, "Op=11");
    do_dp(32'hE280F000, 2'b00, 0, 0, 0, 1, 4'b1111, "ADD PC");
    do_dp(32'hF2801005, 2'b00, 0, 0, 0, 0, 4'b1111, "ADDNV");
    do_dp(32'hE0201000, 2'b00, 0, 0, 1, 1, 4'b1111, "EOR illegal");
    do_dp(32'hE3A04101, 2'b00, 0, 0, 1, 1, 4'b1111, "LSL imm illegal");
    do_dp(32'hE1812002, 2'b11, 0, 0, 0, 1, 4'b1111, "ORR R2");
    do_dp(32'hE0012002, 2'b10, 0, 0, 0, 1, 4'b1111, "AND R2");
    do_dp(32'hE3110001, 2'b10, 0, 1, 0, 1, 4'b1011, "TST R1,#1");    // flags -> 1000
    do_branch(32'h4AFFFFFE, 1, "BMI after TST");
    do_branch(32'h2AFFFFFE, 0, "BCS after TST");
    do_branch(32'h6AFFFFFE, 0, "BVS after TST");
    do_mem(32'hE590F004, 1, "LDR PC");
    do_mem(32'h05802008, 0, "STREQ skipped");
    do_dp(32'hE3510005, 2'b01, 0, 1, 0, 1, 4'b0100, "CMP R1,#5 Z"); // flags -> 0100

    fetch_decode(32'hE2801005, "aborted ADD");
    applyStimulus(base(S_EXECI), 4'b1111, "aborted ADD exec");
    reset = 1'b1;
    applyStimulus(base(S_ALUWB), 4'b1111, "aborted ADD reset in aluwb");
    reset = 1'b0;
    do_branch(32'h0AFFFFFE, 0, "BEQ after mid reset");

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
